d5m_detect_ctrl: RTL and testbench
==================================

# d5m_detect_ctrl

Avalon-MM-controlled sequencer for the D5M motion-detect datapath. It owns the detect threshold, stages CPU writes so a new threshold takes effect only at a frame boundary, and debounces the raw per-frame detect flag over consecutive frames. It also counts detection events and raises a maskable interrupt to the HPS. It sits between the lightweight HPS bridge and the D5M detect logic, feeding it `oThreshold` and consuming its `iDetect`.

## Interface
- `DEBOUNCE_FRAMES`, 2: consecutive frame-end samples needed to enter or leave the detected state (1..15).
- `CNT_W`, 16: width of the event counter (1..32).
- `iClk` in 1: system clock.
- `iRst_n` in 1: reset, asynchronous, active-low.
- `s_cs` in 1: slave chip select.
- `s_read` in 1: read strobe, qualified by `s_cs`.
- `s_write` in 1: write strobe, qualified by `s_cs`.
- `s_address` in 3: word address.
- `s_writedata` in 32: write data.
- `s_readdata` out 32: read data, read latency 1.
- `iDetect` in 1: raw detect flag from the detect datapath (asynchronous).
- `iFVAL` in 1: camera frame-valid (asynchronous).
- `oThreshold` out 32: active threshold to the detect datapath.
- `oIrq` out 1: level interrupt.

## Operation
- Synchronization
  - `iDetect` and `iFVAL` each pass through a 2-flop synchronizer.
  - `fe` is a 1-cycle strobe on the falling edge of synchronized FVAL.
- Register map (word address)
  - 0 CTRL, R/W: bit0 `en` (reset 1), bit1 `irq_en` (reset 0).
  - 1 THRESH_PEND, R/W, reset 0x700. A write sets `upd_pend`.
  - 2 THRESH_ACT, RO: returns `oThreshold`.
  - 3 STATUS: bit0 synced raw detect, bit1 `det`, bit2 `irq_pend` (write 1 to clear), bit3 `upd_pend`. Other bits read 0.
  - 4 EVENT_CNT: `CNT_W` bits, zero-extended. Any write clears it to 0.
  - 5 FRAME_CNT: see Configuration.
  - 6–7: read 0, writes ignored.
- Threshold staging
  - On `fe` with `upd_pend`=1: `oThreshold` ← THRESH_PEND and `upd_pend` ← 0.
  - A THRESH_PEND write in the same cycle as `fe`:
    - `oThreshold` takes the pre-write pending value.
    - The new value is stored in THRESH_PEND.
    - `upd_pend` stays 1.
- Debounce FSM, advanced only on `fe` while `en`=1; `k` is the frame counter, 0..`DEBOUNCE_FRAMES`−1.
  - IDLE: detect=1 → ARM with k=1, or directly to DET if `DEBOUNCE_FRAMES`=1.
  - ARM: detect=1 → k++, and → DET when k reaches `DEBOUNCE_FRAMES`. detect=0 → IDLE.
  - DET: detect=0 → REL with k=1, or directly to IDLE if `DEBOUNCE_FRAMES`=1.
  - REL: detect=0 → k++, and → IDLE when k reaches `DEBOUNCE_FRAMES`. detect=1 → DET.
  - `det`=1 in DET and REL.
  - `en`=0: FSM forced to IDLE and counters hold. Threshold staging continues.
- Events and interrupt
  - Each entry into DET increments EVENT_CNT, saturating at 2^`CNT_W`−1.
  - Each entry into DET sets `irq_pend` if `irq_en`=1.
  - If set and W1C clear land in the same cycle, set wins.
  - `oIrq` = `irq_pend` & `irq_irq_en`... more precisely `oIrq` = `irq_pend` & `irq_en`, combinational from registers.
  - EVENT_CNT clear and increment in the same cycle: result is 0.

## Timing
- Reset values
  - `oThreshold`=0x700, `s_readdata`=0, `oIrq`=0.
  - FSM in IDLE.
  - All counters 0, `upd_pend`=0.
- Read path: `s_readdata` is registered.
  - Data is valid the cycle after `s_cs&s_read`.
  - `s_readdata` is 0 in all other cycles.
- Writes take effect on the clock edge where `s_cs&s_write` is sampled.
- Latency from `iFVAL` falling edge to `fe`: 3 cycles. `oThreshold` and FSM updates land 1 cycle after `fe`.
- Reset asserted mid-frame or mid-debounce returns everything to reset values. The first `fe` after reset is taken only after a synchronized FVAL high is seen.

## Configuration
- `D5M_DETECT_FRAME_CNT_EN` defined:
  - Address 5 returns a 32-bit count of `fe` strobes, wrapping at 2^32 and counting regardless of `en`.
  - Any write to address 5 clears it.
- Not defined: no counter is built, address 5 reads 0, and writes are ignored.

## Test plan
- Reset, then read addresses 0–4 → 0x1, 0x700, 0x700, 0x0, 0x0. `oIrq`=0.
- Write THRESH_PEND=0x900 mid-frame → `oThreshold` stays 0x700 and STATUS bit3=1. One cycle after `fe`, `oThreshold`=0x900 and bit3=0.
- `DEBOUNCE_FRAMES`=2, `irq_en`=1, detect high over 2 frames → DET, EVENT_CNT=1, `oIrq`=1. Write STATUS=0x4 → `oIrq`=0.
- Detect high 1 frame, low 1, high 1 → never DET, EVENT_CNT=0. In DET, detect low 1 frame then high → stays `det`=1 with no new event.
- THRESH_PEND write coincident with `fe` (old pending 0x900, new 0xA00) → `oThreshold`=0x900, `upd_pend`=1. Next `fe` → 0xA00.
- `CNT_W`=2: 4 detection events → EVENT_CNT=3 (saturated). Write address 4 → 0. `en`=0 with detect high → no events.

Source files
------------

// File: rtl/d5m_detect_ctrl_if.sv
// Avalon-MM slave bus between the lightweight HPS bridge and d5m_detect_ctrl.
// Handshake: a transfer happens on every clock edge that samples s_cs with s_read or s_write high;
// there is no waitrequest, and read data is returned in s_readdata exactly one cycle later.
interface d5m_detect_ctrl_if;
    logic        s_cs;
    logic        s_read;
    logic        s_write;
    logic [2:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    modport master (
        output s_cs, s_read, s_write, s_address, s_writedata,
        input  s_readdata
    );

    modport slave (
        input  s_cs, s_read, s_write, s_address, s_writedata,
        output s_readdata
    );
endinterface

// File: rtl/d5m_detect_ctrl.sv
// D5M motion-detect sequencer: frame-boundary threshold staging, detect debounce, event count, IRQ.
// Optional build macro D5M_DETECT_FRAME_CNT_EN adds a frame-end counter at word address 5.
module d5m_detect_ctrl #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int CNT_W           = 16
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    d5m_detect_ctrl_if.slave       bus,
    input  logic                   iDetect,
    input  logic                   iFVAL,
    output logic [31:0]            oThreshold,
    output logic                   oIrq,
    output logic [1:0]             oDbgState
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_DET  = 2'd2,
        S_REL  = 2'd3
    } state_t;

    localparam logic [3:0]       DF4     = 4'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             det_s1_q, det_s2_q;
    logic             fval_s1_q, fval_s2_q, fval_s3_q;
    logic             fe_q;
    state_t           state_q;
    logic [3:0]       k_q;
    logic             en_q, irq_en_q;
    logic [31:0]      thresh_pend_q, thresh_act_q;
    logic             upd_pend_q, irq_pend_q;
    logic [CNT_W-1:0] event_cnt_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      frame_rd;
    logic             wr, rd, enter_det, det;

    assign wr  = bus.s_cs & bus.s_write;
    assign rd  = bus.s_cs & bus.s_read;
    assign det = (state_q == S_DET) || (state_q == S_REL);

    // Only IDLE/ARM can enter DET; REL returning to DET is the same detection, not a new event.
    assign enter_det = fe_q & en_q & det_s2_q &
                       (((state_q == S_IDLE) && (DF4 == 4'd1)) ||
                        ((state_q == S_ARM) && ((k_q + 4'd1) == DF4)));

    // fval_s3_q starts low so the first fe needs a synchronized FVAL high after reset.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            det_s1_q  <= 1'b0;
            det_s2_q  <= 1'b0;
            fval_s1_q <= 1'b0;
            fval_s2_q <= 1'b0;
            fval_s3_q <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            det_s1_q  <= iDetect;
            det_s2_q  <= det_s1_q;
            fval_s1_q <= iFVAL;
            fval_s2_q <= fval_s1_q;
            fval_s3_q <= fval_s2_q;
            fe_q      <= fval_s3_q & ~fval_s2_q;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
        end else if (!en_q) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
        end else if (fe_q) begin
            case (state_q)
                S_IDLE: if (det_s2_q) begin
                    if (DF4 == 4'd1) begin
                        state_q <= S_DET;
                        k_q     <= 4'd0;
                    end else begin
                        state_q <= S_ARM;
                        k_q     <= 4'd1;
                    end
                end
                S_ARM: if (det_s2_q) begin
                    if ((k_q + 4'd1) == DF4) begin
                        state_q <= S_DET;
                        k_q     <= 4'd0;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end else begin
                    state_q <= S_IDLE;
                    k_q     <= 4'd0;
                end
                S_DET: if (!det_s2_q) begin
                    if (DF4 == 4'd1) begin
                        state_q <= S_IDLE;
                        k_q     <= 4'd0;
                    end else begin
                        state_q <= S_REL;
                        k_q     <= 4'd1;
                    end
                end
                S_REL: if (!det_s2_q) begin
                    if ((k_q + 4'd1) == DF4) begin
                        state_q <= S_IDLE;
                        k_q     <= 4'd0;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end else begin
                    state_q <= S_DET;
                    k_q     <= 4'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                    k_q     <= 4'd0;
                end
            endcase
        end
    end

    // Staging uses the pre-write pending value, so a coincident write stays pending for the next frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            en_q          <= 1'b1;
            irq_en_q      <= 1'b0;
            thresh_pend_q <= 32'h700;
            thresh_act_q  <= 32'h700;
            upd_pend_q    <= 1'b0;
            irq_pend_q    <= 1'b0;
            event_cnt_q   <= '0;
            rdata_q       <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
            if (wr && bus.s_address == 3'd0) begin
                en_q     <= bus.s_writedata[0];
                irq_en_q <= bus.s_writedata[1];
            end
            if (fe_q && upd_pend_q)
                thresh_act_q <= thresh_pend_q;
            if (wr && bus.s_address == 3'd1) begin
                thresh_pend_q <= bus.s_writedata;
                upd_pend_q    <= 1'b1;
            end else if (fe_q && upd_pend_q) begin
                upd_pend_q <= 1'b0;
            end
            if (enter_det && irq_en_q)
                irq_pend_q <= 1'b1;
            else if (wr && bus.s_address == 3'd3 && bus.s_writedata[2])
                irq_pend_q <= 1'b0;
            if (wr && bus.s_address == 3'd4)
                event_cnt_q <= '0;
            else if (enter_det && event_cnt_q != CNT_MAX)
                event_cnt_q <= event_cnt_q + 1'b1;
        end
    end

`ifdef D5M_DETECT_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            frame_cnt_q <= 32'd0;
        else if (wr && bus.s_address == 3'd5)
            frame_cnt_q <= 32'd0;
        else if (fe_q)
            frame_cnt_q <= frame_cnt_q + 32'd1;
    end

    assign frame_rd = frame_cnt_q;
`else
    assign frame_rd = 32'd0;
`endif

    always_comb begin
        rdata_d = 32'd0;
        if (rd) begin
            case (bus.s_address)
                3'd0:    rdata_d = {30'd0, irq_en_q, en_q};
                3'd1:    rdata_d = thresh_pend_q;
                3'd2:    rdata_d = thresh_act_q;
                3'd3:    rdata_d = {28'd0, upd_pend_q, irq_pend_q, det, det_s2_q};
                3'd4:    rdata_d = 32'(event_cnt_q);
                3'd5:    rdata_d = frame_rd;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    assign bus.s_readdata = rdata_q;
    assign oThreshold     = thresh_act_q;
    assign oIrq           = irq_pend_q & irq_en_q;
    assign oDbgState      = state_q;
endmodule

// File: tb/tb_d5m_detect_ctrl.sv
// Bench for d5m_detect_ctrl: directed scenarios plus random frames checked against a frame-level model.
module tb_d5m_detect_ctrl;
    localparam int DF      = 2;
    localparam int CW      = 2;
    localparam int EVT_MAX = (1 << CW) - 1;

    // clock / reset
    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    d5m_detect_ctrl_if bus_if();
    logic        iDetect = 1'b0;
    logic        iFVAL = 1'b0;
    logic [31:0] oThreshold;
    logic        oIrq;
    logic [1:0]  oDbgState;

    d5m_detect_ctrl #(.DEBOUNCE_FRAMES(DF), .CNT_W(CW)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .bus(bus_if),
        .iDetect(iDetect), .iFVAL(iFVAL),
        .oThreshold(oThreshold), .oIrq(oIrq), .oDbgState(oDbgState)
    );

    // scoreboard state
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_q[$];

    // frame-level reference model
    bit          m_en, m_irq_en, m_upd, m_det, m_irq;
    logic [31:0] m_pend, m_act;
    int          m_run, m_evt;
    int unsigned m_frames;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 1; m_irq_en = 0; m_upd = 0; m_det = 0; m_irq = 0;
        m_pend = 32'h700; m_act = 32'h700; m_run = 0; m_evt = 0; m_frames = 0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        case (a)
            0: begin
                m_en = d[0]; m_irq_en = d[1];
                if (!m_en) begin m_det = 0; m_run = 0; end
            end
            1: begin m_pend = d; m_upd = 1; end
            3: if (d[2]) m_irq = 0;
            4: m_evt = 0;
            5: m_frames = 0;
            default: ;
        endcase
    endtask

    // The debounced flag flips after DF consecutive frame samples that disagree with it.
    task automatic model_fe(input bit d);
        m_frames++;
        if (m_upd) begin m_act = m_pend; m_upd = 0; end
        if (m_en) begin
            if (d != m_det) begin
                m_run++;
                if (m_run == DF) begin
                    m_det = d;
                    m_run = 0;
                    if (d) begin
                        if (m_evt < EVT_MAX) m_evt++;
                        if (m_irq_en) m_irq = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // driver tasks
    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge iClk);
        bus_if.s_cs = 1; bus_if.s_write = 1; bus_if.s_address = 3'(a); bus_if.s_writedata = d;
        @(negedge iClk);
        bus_if.s_cs = 0; bus_if.s_write = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus_write(a, d);
        model_write(a, d);
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge iClk);
        bus_if.s_cs = 1; bus_if.s_read = 1; bus_if.s_address = 3'(a);
        @(negedge iClk);
        bus_if.s_cs = 0; bus_if.s_read = 0;
        d = bus_if.s_readdata;
    endtask

    function automatic logic [31:0] exp_status();
        return {28'd0, m_upd, m_irq, m_det, iDetect};
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] rd;
        exp_q.push_back({30'd0, m_irq_en, m_en});
        exp_q.push_back(m_pend);
        exp_q.push_back(m_act);
        exp_q.push_back(exp_status());
        exp_q.push_back(32'(m_evt));
`ifdef D5M_DETECT_FRAME_CNT_EN
        exp_q.push_back(32'(m_frames));
`else
        exp_q.push_back(32'd0);
`endif
        for (int a = 0; a < 6; a++) begin
            bus_read(a, rd);
            check_eq($sformatf("%s_rd%0d", tag, a), rd, exp_q.pop_front());
        end
        @(negedge iClk);
        check_eq({tag, "_rd_idle"}, bus_if.s_readdata, 32'd0);
        check_eq({tag, "_thr"}, oThreshold, m_act);
        check_eq({tag, "_irq"}, 32'(oIrq), 32'(m_irq & m_irq_en));
    endtask

    // mode 0: no threshold write, 1: write mid-frame, 2: write on the fe cycle
    task automatic run_frame(input bit d, input int mode, input logic [31:0] thr);
        logic [31:0] rd;
        @(negedge iClk);
        iDetect = d; iFVAL = 1;
        repeat (5) @(negedge iClk);
        if (mode == 1) begin
            wr(1, thr);
            check_eq("mid_thr_hold", oThreshold, m_act);
            bus_read(3, rd);
            check_eq("mid_status", rd, exp_status());
        end
        @(negedge iClk);
        iFVAL = 0;
        if (mode == 2) begin
            repeat (3) @(posedge iClk);
            bus_write(1, thr);
            model_fe(d);
            model_write(1, thr);
            repeat (4) @(negedge iClk);
        end else begin
            repeat (6) @(negedge iClk);
            model_fe(d);
        end
    endtask

    task automatic do_reset();
        iRst_n = 0;
        bus_if.s_cs = 0; bus_if.s_read = 0; bus_if.s_write = 0;
        bus_if.s_address = 3'd0; bus_if.s_writedata = 32'd0;
        iFVAL = 0; iDetect = 0;
        repeat (3) @(negedge iClk);
        iRst_n = 1;
        model_reset();
    endtask

    initial begin
        logic [31:0] rd;
        do_reset();
        check_all("reset");
        bus_read(6, rd);
        check_eq("rd_addr6", rd, 32'd0);
        check_eq("reset_state", 32'(oDbgState), 32'd0);

        // a single-frame glitch pattern must not debounce in
        run_frame(1, 0, 0); run_frame(0, 0, 0); run_frame(1, 0, 0);
        check_all("glitch");

        wr(0, 32'h3);
        run_frame(1, 0, 0);
        check_all("det_entry");
        check_eq("det_irq_hi", 32'(oIrq), 32'd1);
        wr(3, 32'h4);
        check_eq("w1c_irq_lo", 32'(oIrq), 32'd0);
        run_frame(0, 0, 0); run_frame(1, 0, 0);
        check_all("rel_back");

        run_frame(0, 1, 32'h900);
        check_all("stage_900");
        check_eq("stage_900_thr", oThreshold, 32'h900);

        wr(1, 32'h900);
        run_frame(0, 2, 32'hA00);
        check_all("coinc");
        check_eq("coinc_thr", oThreshold, 32'h900);
        run_frame(0, 0, 0);
        check_all("coinc_next");
        check_eq("coinc_next_thr", oThreshold, 32'hA00);

        for (int i = 0; i < 4; i++) begin
            run_frame(1, 0, 0); run_frame(1, 0, 0);
            run_frame(0, 0, 0); run_frame(0, 0, 0);
        end
        check_all("sat");
        bus_read(4, rd);
        check_eq("evt_saturated", rd, 32'd3);
        wr(4, 32'h0);
        wr(0, 32'h2);
        run_frame(1, 0, 0); run_frame(1, 0, 0); run_frame(1, 0, 0);
        check_all("en_off");

        // asynchronous reset in the middle of a debounce
        wr(0, 32'h3);
        run_frame(1, 0, 0);
        @(negedge iClk);
        iDetect = 1; iFVAL = 1;
        repeat (3) @(negedge iClk);
        #2 iRst_n = 0;
        #1 check_eq("async_rst_thr", oThreshold, 32'h700);
        check_eq("async_rst_irq", 32'(oIrq), 32'd0);
        @(negedge iClk);
        iRst_n = 1;
        model_reset();
        run_frame(1, 0, 0);
        check_all("post_rst");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0)
                wr(0, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            if ($urandom_range(0, 5) == 0) wr(3, 32'h4);
            if ($urandom_range(0, 9) == 0) wr(4, $urandom);
            if ($urandom_range(0, 11) == 0) wr(5, $urandom);
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
            check_all($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
